// File: rtl/router_pkg.sv
// Shared constants for the router output-side blocks: default port count,
// default watchdog timeout and width of the per-port timeout event counters.
package router_pkg;
  localparam int ROUTER_DEF_PORTS   = 3;
  localparam int ROUTER_DEF_TIMEOUT = 30;
  localparam int TMO_CNT_W          = 8;
endpackage

// File: rtl/router_tmo_timer.sv
// One output-port stall watchdog: pulses soft_reset for one cycle after TIMEOUT
// consecutive stalled edges. ROUTER_SYNC_TMO_CNT_EN adds a saturating event counter.
module router_tmo_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_DEF_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 vld,
  input  logic                 read_enb,
`ifdef ROUTER_SYNC_TMO_CNT_EN
  output logic [TMO_CNT_W-1:0] tmo_count,
`endif
  output logic                 soft_reset
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic             stall;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             soft_reset_d, soft_reset_q;

  // Any non-stalled edge drops the count back to zero.
  always_comb begin
    stall        = vld & ~read_enb;
    cnt_d        = '0;
    soft_reset_d = 1'b0;
    if (stall) begin
      if (cnt_q == CNT_LAST) begin
        soft_reset_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;

`ifdef ROUTER_SYNC_TMO_CNT_EN
  logic [TMO_CNT_W-1:0] tmo_cnt_d, tmo_cnt_q;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (soft_reset_d && (tmo_cnt_q != '1)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign tmo_count = tmo_cnt_q;
`endif

endmodule

// File: rtl/router_sync_n.sv
// Synchroniser between router FSM and NUM_PORTS output FIFOs: address latch,
// write steering, full mux, valid flags and per-port stall watchdogs.
// Optional macro ROUTER_SYNC_TMO_CNT_EN exposes per-port timeout event counters.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_PORTS = ROUTER_DEF_PORTS,
  parameter int ADDR_W    = $clog2(NUM_PORTS),
  parameter int TIMEOUT   = ROUTER_DEF_TIMEOUT
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           detect_add,
  input  logic                           write_enb_reg,
  input  logic [ADDR_W-1:0]              data_in,
  input  logic [NUM_PORTS-1:0]           read_enb,
  input  logic [NUM_PORTS-1:0]           empty,
  input  logic [NUM_PORTS-1:0]           full,
  output logic [NUM_PORTS-1:0]           write_enb,
  output logic [NUM_PORTS-1:0]           vld_out,
  output logic [NUM_PORTS-1:0]           soft_reset,
`ifdef ROUTER_SYNC_TMO_CNT_EN
  output logic [TMO_CNT_W*NUM_PORTS-1:0] tmo_count,
`endif
  output logic                           fifo_full,
  output logic                           addr_err
);

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              addr_err_d, addr_err_q;

  always_comb begin
    addr_d     = addr_q;
    addr_err_d = addr_err_q;
    if (detect_add) begin
      addr_d     = data_in;
      addr_err_d = (int'(data_in) >= NUM_PORTS);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      addr_err_q <= addr_err_d;
    end
  end

  // An errored packet is written nowhere and never back-pressured, so it drains.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    if (resetn && !addr_err_q) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (addr_q == ADDR_W'(i)) begin
          write_enb[i] = write_enb_reg;
          fifo_full    = full[i];
        end
      end
    end
  end

  assign addr_err = addr_err_q;
  assign vld_out  = ~empty;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_tmo
    router_tmo_timer #(
      .TIMEOUT (TIMEOUT)
    ) u_tmo (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (vld_out[g]),
      .read_enb   (read_enb[g]),
`ifdef ROUTER_SYNC_TMO_CNT_EN
      .tmo_count  (tmo_count[g*TMO_CNT_W +: TMO_CNT_W]),
`endif
      .soft_reset (soft_reset[g])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n (3 ports, timeout 30): address latch and
// steering, out-of-range drop, watchdog timing, restart and reset behaviour.
module tb_router_sync_n;
  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 2;
  localparam int TIMEOUT   = 30;

  logic                 clock = 1'b0;
  logic                 resetn;
  logic                 detect_add;
  logic                 write_enb_reg;
  logic [ADDR_W-1:0]    data_in;
  logic [NUM_PORTS-1:0] read_enb;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] write_enb;
  logic [NUM_PORTS-1:0] vld_out;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 fifo_full;
  logic                 addr_err;
`ifdef ROUTER_SYNC_TMO_CNT_EN
  logic [8*NUM_PORTS-1:0] tmo_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  router_sync_n #(
    .NUM_PORTS (NUM_PORTS),
    .ADDR_W    (ADDR_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .write_enb_reg (write_enb_reg),
    .data_in       (data_in),
    .read_enb      (read_enb),
    .empty         (empty),
    .full          (full),
    .write_enb     (write_enb),
    .vld_out       (vld_out),
    .soft_reset    (soft_reset),
`ifdef ROUTER_SYNC_TMO_CNT_EN
    .tmo_count     (tmo_count),
`endif
    .fifo_full     (fifo_full),
    .addr_err      (addr_err)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    detect_add    = 1'b0;
    write_enb_reg = 1'b0;
    data_in       = '0;
    read_enb      = '0;
    empty         = '1;
    full          = '0;
  endtask

  // Run n edges, expecting soft_reset == pulse_val only on edges that are
  // multiples of TIMEOUT (counted from 1) and zero elsewhere.
  task automatic run_stall(input string tag, input int n, input logic [2:0] pulse_val);
    for (int k = 1; k <= n; k++) begin
      step();
      check(tag, 32'(soft_reset), (k % TIMEOUT == 0) ? 32'(pulse_val) : 32'd0);
    end
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    write_enb_reg = 1'b1;
    step();
    step();
    check("rst_write_enb", 32'(write_enb), 32'd0);
    check("rst_soft_reset", 32'(soft_reset), 32'd0);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_vld_out", 32'(vld_out), 32'd0);
    full = 3'b001;
    #1;
    check("rst_fifo_full_gated", 32'(fifo_full), 32'd0);
    empty = 3'b110;
    #1;
    check("rst_vld_follows_empty", 32'(vld_out), 32'b001);
`ifdef ROUTER_SYNC_TMO_CNT_EN
    check("rst_tmo_count", 32'(tmo_count), 32'd0);
`endif

    // Header to port 1; write strobe same cycle still uses old address 0.
    idle_inputs();
    resetn        = 1'b1;
    detect_add    = 1'b1;
    data_in       = 2'd1;
    write_enb_reg = 1'b1;
    #1;
    check("pre_latch_write_enb", 32'(write_enb), 32'b001);
    step();
    detect_add = 1'b0;
    data_in    = 2'd0;
    #1;
    check("addr1_write_enb", 32'(write_enb), 32'b010);
    check("addr1_addr_err", 32'(addr_err), 32'd0);
    full = 3'b010;
    #1;
    check("addr1_fifo_full_set", 32'(fifo_full), 32'd1);
    full = 3'b101;
    #1;
    check("addr1_fifo_full_clr", 32'(fifo_full), 32'd0);
    write_enb_reg = 1'b0;
    #1;
    check("addr1_no_strobe", 32'(write_enb), 32'd0);

    // Out-of-range header, then a valid one clears the error.
    detect_add = 1'b1;
    data_in    = 2'd3;
    step();
    detect_add    = 1'b0;
    write_enb_reg = 1'b1;
    full          = 3'b111;
    #1;
    check("err_addr_err", 32'(addr_err), 32'd1);
    check("err_write_enb", 32'(write_enb), 32'd0);
    check("err_fifo_full", 32'(fifo_full), 32'd0);
    detect_add = 1'b1;
    data_in    = 2'd2;
    #1;
    check("err_held_before_edge", 32'(addr_err), 32'd1);
    step();
    detect_add = 1'b0;
    #1;
    check("addr2_addr_err", 32'(addr_err), 32'd0);
    check("addr2_write_enb", 32'(write_enb), 32'b100);
    check("addr2_fifo_full", 32'(fifo_full), 32'd1);

    // Port 0 stalled 60 edges: pulses after edge 30 and edge 60.
    idle_inputs();
    empty = 3'b110;
    run_stall("stall60", 2 * TIMEOUT, 3'b001);
    empty = 3'b111;
    step();
    check("stall60_release", 32'(soft_reset), 32'd0);

    // 29 stalled edges, one read edge, then a full fresh window is needed.
    empty = 3'b110;
    run_stall("restart_pre", TIMEOUT - 1, 3'b001);
    read_enb = 3'b001;
    step();
    check("restart_read_edge", 32'(soft_reset), 32'd0);
    read_enb = 3'b000;
    run_stall("restart_post", TIMEOUT, 3'b001);

    // Fresh reset, then ports 0 and 2 stall together.
    idle_inputs();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    empty  = 3'b010;
    run_stall("dual_stall", TIMEOUT, 3'b101);
`ifdef ROUTER_SYNC_TMO_CNT_EN
    check("dual_tmo_count", 32'(tmo_count), 32'h01_00_01);
`endif
    empty = 3'b111;
    step();
    check("dual_release", 32'(soft_reset), 32'd0);

    // Reset asserted at stall edge 21: no pulse at edge 30, a full window after.
    empty = 3'b110;
    run_stall("rst_mid_pre", 20, 3'b001);
    resetn = 1'b0;
    step();
    check("rst_mid_edge", 32'(soft_reset), 32'd0);
`ifdef ROUTER_SYNC_TMO_CNT_EN
    check("rst_mid_tmo_count", 32'(tmo_count), 32'd0);
`endif
    resetn = 1'b1;
    run_stall("rst_mid_post", TIMEOUT, 3'b001);
    empty = 3'b111;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/router_sync_n.md
# router_sync_n

Parametrised synchroniser between the router FSM and its NUM_PORTS output FIFOs. Latches the destination address on header detect, steers the FSM write strobe to one FIFO, muxes that FIFO's full flag back to the FSM, and publishes per-port valid flags. Runs a per-port stall watchdog that soft-resets a FIFO when its reader idles too long. Also flags out-of-range destination addresses and drops their packets.

## Interface
- NUM_PORTS, 3: number of output FIFOs/ports, 2..16
- ADDR_W, $clog2(NUM_PORTS): width of destination address field
- TIMEOUT, 30: consecutive stalled cycles before soft reset, 2..255
- clock  in  1  single clock, all state on rising edge
- resetn  in  1  synchronous, active-low reset
- detect_add  in  1  header byte present, latch data_in
- write_enb_reg  in  1  FSM write strobe for current packet
- data_in  in  ADDR_W  destination address from header
- read_enb  in  NUM_PORTS  per-port reader read enable
- empty  in  NUM_PORTS  per-port FIFO empty
- full  in  NUM_PORTS  per-port FIFO full
- write_enb  out  NUM_PORTS  one-hot FIFO write enable
- vld_out  out  NUM_PORTS  per-port data valid
- soft_reset  out  NUM_PORTS  per-port one-cycle FIFO flush pulse
- fifo_full  out  1  full flag of addressed FIFO
- addr_err  out  1  latched address is out of range
- tmo_count  out  8*NUM_PORTS  per-port timeout event counters (ROUTER_SYNC_TMO_CNT_EN only)

## Operation
- Address register: on posedge with resetn low -> addr=0, addr_err=0. Else if detect_add -> addr=data_in, addr_err=(data_in >= NUM_PORTS). Held otherwise.
- write_enb (combinational): all zero if !resetn, !write_enb_reg or addr_err; else bit addr set, others clear.
- fifo_full (combinational): 0 if !resetn or addr_err; else full[addr]. An errored packet is thus written nowhere and never back-pressured (silently drained).
- vld_out[i] = ~empty[i], purely combinational, unaffected by reset.
- Watchdog per port i, stall_i = vld_out[i] & ~read_enb[i]. Per posedge:
  - !resetn: cnt=0, soft_reset[i]=0
  - !stall_i: cnt=0, soft_reset[i]=0
  - stall_i and cnt==TIMEOUT-1: cnt=0, soft_reset[i]=1
  - else: cnt=cnt+1, soft_reset[i]=0
- Counter width $clog2(TIMEOUT); never wraps (cleared at TIMEOUT-1).
- Ports are independent; simultaneous timeouts on several ports all pulse in the same cycle.
- detect_add concurrent with write_enb_reg: write_enb uses the pre-update address this cycle, new address from next cycle.

## Timing
- Reset values: write_enb=0, soft_reset=0, fifo_full=0, addr_err=0, tmo_count=0; vld_out follows empty.
- Address latency: 1 cycle from detect_add edge to write_enb/fifo_full/addr_err change.
- write_enb, fifo_full: zero-latency from write_enb_reg/full.
- soft_reset[i] high for exactly the one cycle following the TIMEOUT-th consecutive stalled edge; if stall persists, next pulse after another TIMEOUT edges.
- One non-stalled edge anywhere in the window restarts the count from 0.
- resetn low mid-count: counters and pulses cleared at that edge.

## Configuration
- ROUTER_SYNC_TMO_CNT_EN defined: tmo_count port and logic present; field i (bits 8i+7:8i) increments on each edge where soft_reset[i] is set next, saturating at 255, cleared only by reset.
- Undefined: port and counters absent; all other behaviour identical.

## Structure
- Shared package router_pkg: ROUTER_DEF_PORTS=3, ROUTER_DEF_TIMEOUT=30, TMO_CNT_W=8 constants.
- Sub-module router_tmo_timer: one watchdog (counter, soft_reset, optional tmo counter), instantiated NUM_PORTS times via generate.

## Test plan
- Reset then detect_add with data_in=1, write_enb_reg=1 -> write_enb=3'b010 one cycle after latch; full[1]=1 -> fifo_full=1.
- data_in=3 with NUM_PORTS=3 -> addr_err=1, write_enb=0, fifo_full=0 despite full=3'b111; next header data_in=2 clears addr_err.
- empty[0]=0, read_enb[0]=0 held 30 cycles (TIMEOUT=30) -> soft_reset[0] pulses one cycle after 30th edge; held 60 cycles -> two pulses 30 cycles apart.
- Stall 29 cycles, one cycle read_enb[0]=1, stall again -> no pulse until 30 further stalled cycles.
- Ports 0 and 2 stalled from the same cycle -> soft_reset=3'b101 in one cycle; with macro, tmo_count fields 0 and 2 read 1.
- resetn low at stall cycle 20 -> no pulse; count restarts; NUM_PORTS=5, TIMEOUT=4 build repeats scenarios 1 and 3.
